// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial two's-complement adder/subtractor. One full adder and one carry
//   flip-flop process the operands LSB first, one bit per clock. Subtraction is
//   a + ~b + 1: the B operand is inverted on load and the carry is preset to 1.
//   Latency from the start edge to the done pulse is WIDTH+1 cycles.
//
// Parameters
//   WIDTH   operand width in bits (2..32)
//
// Ports
//   clk     clock, rising edge
//   rst     synchronous reset, active low
//   start   begin an operation (accepted when not busy)
//   sub     0 = a+b, 1 = a-b, sampled with start
//   a, b    operands, sampled with start
//   busy    high while serial bits are being processed
//   done    one-cycle pulse; result and ovf are valid from this cycle on
//   result  {carry_out, sum[WIDTH-1:0]}, held until the next done
//   ovf     signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // The single full adder working on the current LSBs.
  logic sum_bit;
  logic carry_next;

  assign sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: every register here uses non-blocking assignment so all updates in
  // one edge see the pre-edge values; blocking would make the shift order
  // depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: these are plain flip-flops, not a RAM, so clearing them all on
      // reset is cheap and makes an aborted operation leave no residue.
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately not looked at here: operands stay put.
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
          carry  <= carry_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // Last bit is the MSB: publish the assembled sum together with the
            // final carry; carry still holds the carry into the MSB here.
            result <= {carry_next, sum_bit, res_sr[WIDTH-1:1]};
            ovf    <= carry ^ carry_next;
            state  <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled each rising edge.
REQ-005 sub  input  1  mode: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  WIDTH  first operand; sampled with start.
REQ-007 b  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high while serial bits are being processed.
REQ-009 done  output  1  one-cycle pulse; result and ovf are valid from this cycle.
REQ-010 result  output  WIDTH+1  {carry_out, sum[WIDTH-1:0]}.
REQ-011 ovf  output  1  two's-complement signed overflow flag of the operation.

Function
REQ-012 The block SHALL be a three-state FSM with states IDLE, RUN and DONE, using one 1-bit full adder and one carry flip-flop (bit-serial, LSB first).
REQ-013 In IDLE or DONE, start=1 at an edge SHALL load a into the A shift register and (sub ? ~b : b) into the B shift register, set carry to sub, clear the bit counter and enter RUN.
REQ-014 In RUN, each edge SHALL add A[0], B[0] and carry, shift the sum bit into the result shift register from the MSB side, shift A and B right by one, update carry, and increment the counter.
REQ-015 After the WIDTH-th RUN cycle the FSM SHALL enter DONE; DONE lasts exactly one cycle, then returns to IDLE unless start=1 (REQ-013).
REQ-016 Latency: with start sampled at edge 0, busy SHALL be 1 for cycles 1..WIDTH and done SHALL be 1 in cycle WIDTH+1 only.
REQ-017 result[WIDTH-1:0] SHALL equal (a + b) mod 2^WIDTH when sub=0, and (a - b) mod 2^WIDTH when sub=1.
REQ-018 result[WIDTH] SHALL be the final carry: the unsigned carry for add; 1 = no borrow (a >= b unsigned) for sub.
REQ-019 ovf SHALL be the XOR of the carry into and the carry out of the MSB bit position.
REQ-020 result and ovf SHALL be registered and SHALL hold their values from done until the next done; they SHALL NOT change during RUN.
REQ-021 start=1 while in RUN SHALL be ignored: no reload, no state change, and operands stay unchanged.
REQ-022 Changes on a, b or sub after the start edge SHALL NOT affect the operation in progress.
REQ-023 start held high continuously SHALL produce back-to-back operations with period WIDTH+1 cycles.
REQ-024 busy and done SHALL never be high in the same cycle.

Reset
REQ-025 rst=0 at an edge SHALL force IDLE and clear busy, done, result, ovf, the carry, the counter and all shift registers to 0, including in the middle of an operation.
REQ-026 While rst=0, start SHALL be ignored; the first start is accepted at the first edge with rst=1.
REQ-027 There SHALL be no reliance on initial values; behaviour before the first reset is undefined.

Verification (WIDTH=8 unless noted)
REQ-028 a=200, b=100, sub=0 -> done 9 cycles after the start edge, result=9'h12C, ovf=0; busy is high for exactly 8 cycles.
REQ-029 a=3, b=5, sub=1 -> result=9'h0FE (borrow), ovf=0; a=5, b=3, sub=1 -> result=9'h102.
REQ-030 a=8'h7F, b=1, sub=0 -> result=9'h080, ovf=1; a=8'h80, b=1, sub=1 -> result=9'h17F, ovf=1.
REQ-031 Start accepted, then start pulsed again in cycle 4 with different operands -> first result unaffected; exactly one done pulse.
REQ-032 rst=0 asserted in cycle 5 of RUN -> next cycle busy=0, done=0, result=0; no done pulse follows; a new start then completes correctly.
REQ-033 WIDTH=16, start held high for 3 operations -> done pulses 17 cycles apart, each result is correct; the random-operand model comparison passes for WIDTH in {2, 8, 32}.
